// File: rtl/sand_mem_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sand_mem_pkg;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_P0,
      GNT_P1
   } grant_t;

   localparam int   ADDR_W    = 24;
   localparam int   DATA_W    = 16;
   localparam logic PORT_DISP = 1'b0;
   localparam logic PORT_SAND = 1'b1;

endpackage

// File: rtl/sand_mem_arbiter_rd_tag_fifo.sv
// Read tag FIFO: remembers which port issued each outstanding read so
// in-order responses can be steered back to it.
module rd_tag_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     i_clock,
   input  logic                     i_reset_n,
   input  logic                     i_push,
   input  logic                     i_tag,
   input  logic                     i_pop,
   output logic                     o_full,
   output logic                     o_empty,
   output logic                     o_head,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic             r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_head    = r_mem[r_rd_ptr];
   assign o_count   = r_count;
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   // Pointer and occupancy tracking; pointers wrap naturally (power-of-2 depth).
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
      end
   end

   // Tag storage; contents are meaningless until written, so no reset needed.
   always_ff @(posedge i_clock) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_tag;
   end

endmodule

// File: rtl/sand_mem_arbiter.sv
// Two-port Avalon-MM arbiter in front of the SDRAM controller.
// Port 0 (display, read-only) has priority; port 1 (sand engine) is forced
// through after STARVE_LIM back-to-back port-0 transfers. Read responses are
// routed by a tag FIFO with zero added latency.
module sand_mem_arbiter #(
   parameter int ADDR_W     = sand_mem_pkg::ADDR_W,
   parameter int DATA_W     = sand_mem_pkg::DATA_W,
   parameter int MAX_OUTST  = 4,
   parameter int STARVE_LIM = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] p0_address,
   input  logic              p0_read,
   output logic              p0_waitrequest,
   output logic              p0_readdatavalid,
   output logic [DATA_W-1:0] p0_readdata,
   input  logic [ADDR_W-1:0] p1_address,
   input  logic              p1_read,
   input  logic              p1_write,
   input  logic [DATA_W-1:0] p1_writedata,
   output logic              p1_waitrequest,
   output logic              p1_readdatavalid,
   output logic [DATA_W-1:0] p1_readdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic              mem_waitrequest,
   input  logic              mem_readdatavalid,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic              rsp_error
);
   import sand_mem_pkg::*;

   localparam int CNT_W = $clog2(MAX_OUTST) + 1;
   localparam int SC_W  = $clog2(STARVE_LIM + 1);

   grant_t           r_grant;
   grant_t           w_grant_nx;
   grant_t           w_pick;
   logic [SC_W-1:0]  r_starve_cnt;
   logic [SC_W-1:0]  w_starve_nx;
   logic             r_rsp_error;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic             w_head;
   logic [CNT_W-1:0] w_count;
   logic [CNT_W-1:0] w_count_nx;
   logic             w_rd_block;
   logic             w_p0_rdy;
   logic             w_p1_rdy;
   logic             w_p0_acc;
   logic             w_p1_acc;

   rd_tag_fifo #(
      .DEPTH (MAX_OUTST)
   ) u_tag_fifo (
      .i_clock   (clock),
      .i_reset_n (reset),
      .i_push    (w_push),
      .i_tag     (r_grant == GNT_P1 ? PORT_SAND : PORT_DISP),
      .i_pop     (w_pop),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_head    (w_head),
      .o_count   (w_count)
   );

   // Master-side mux: the granted port drives the SDRAM bus, the other stalls.
   always_comb begin
      mem_address    = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_writedata  = '0;
      p0_waitrequest = 1'b1;
      p1_waitrequest = 1'b1;
      case (r_grant)
         GNT_P0: begin
            mem_address    = p0_address;
            mem_read       = p0_read;
            p0_waitrequest = mem_waitrequest;
         end
         GNT_P1: begin
            mem_address    = p1_address;
            mem_read       = p1_read;
            mem_write      = p1_write;
            mem_writedata  = p1_writedata;
            p1_waitrequest = mem_waitrequest;
         end
         default: ;
      endcase
   end

   assign w_accept = (mem_read | mem_write) & ~mem_waitrequest;
   assign w_p0_acc = w_accept & (r_grant == GNT_P0);
   assign w_p1_acc = w_accept & (r_grant == GNT_P1);
   assign w_push   = w_accept & mem_read;
   assign w_pop    = mem_readdatavalid & ~w_empty;

   // Reads are blocked on the occupancy after this cycle's push/pop, so a
   // grant decided now can never overflow the tag FIFO, and a freed slot is
   // usable immediately.
   assign w_count_nx = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
   assign w_rd_block = w_full ? ~w_pop : (w_count_nx == CNT_W'(MAX_OUTST));
   assign w_p0_rdy   = p0_read & ~w_rd_block;
   assign w_p1_rdy   = p1_write | (p1_read & ~w_rd_block);

   // Starvation counter update and arbitration; the decision looks at the
   // count including this cycle's acceptance so the forced grant lands right
   // after the STARVE_LIM-th port-0 transfer.
   always_comb begin
      w_starve_nx = r_starve_cnt;
      if (!w_p1_rdy || w_p1_acc) begin
         w_starve_nx = '0;
      end else if (w_p0_acc && (r_starve_cnt != SC_W'(STARVE_LIM))) begin
         w_starve_nx = r_starve_cnt + SC_W'(1);
      end

      w_pick = GNT_NONE;
      if (w_p1_rdy && (w_starve_nx == SC_W'(STARVE_LIM))) w_pick = GNT_P1;
      else if (w_p0_rdy)                                  w_pick = GNT_P0;
      else if (w_p1_rdy)                                  w_pick = GNT_P1;
   end

   // Grant next-state: re-arbitrate when idle or on acceptance, hold while
   // stalled, and fall back to idle if the owner abandons its request.
   always_comb begin
      w_grant_nx = r_grant;
      case (r_grant)
         GNT_NONE: w_grant_nx = w_pick;
         GNT_P0: begin
            if (w_accept)      w_grant_nx = w_pick;
            else if (!p0_read) w_grant_nx = GNT_NONE;
         end
         GNT_P1: begin
            if (w_accept)                   w_grant_nx = w_pick;
            else if (!(p1_read | p1_write)) w_grant_nx = GNT_NONE;
         end
         default: w_grant_nx = GNT_NONE;
      endcase
   end

   // Control state registers: grant, starvation count, sticky response error.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_grant      <= GNT_NONE;
         r_starve_cnt <= '0;
         r_rsp_error  <= 1'b0;
      end else begin
         r_grant      <= w_grant_nx;
         r_starve_cnt <= w_starve_nx;
         if (mem_readdatavalid && w_empty) r_rsp_error <= 1'b1;
      end
   end

   assign rsp_error        = r_rsp_error;
   assign p0_readdata      = mem_readdata;
   assign p1_readdata      = mem_readdata;
   assign p0_readdatavalid = mem_readdatavalid & ~w_empty & (w_head == PORT_DISP);
   assign p1_readdatavalid = mem_readdatavalid & ~w_empty & (w_head == PORT_SAND);

endmodule

// File: tb/tb_sand_mem_arbiter.sv
// Scoreboard bench for sand_mem_arbiter: inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_sand_mem_arbiter;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] p0_address;
   logic              p0_read;
   logic              p0_waitrequest;
   logic              p0_readdatavalid;
   logic [DATA_W-1:0] p0_readdata;
   logic [ADDR_W-1:0] p1_address;
   logic              p1_read;
   logic              p1_write;
   logic [DATA_W-1:0] p1_writedata;
   logic              p1_waitrequest;
   logic              p1_readdatavalid;
   logic [DATA_W-1:0] p1_readdata;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_writedata;
   logic              mem_waitrequest;
   logic              mem_readdatavalid;
   logic [DATA_W-1:0] mem_readdata;
   logic              rsp_error;

   int checks = 0;
   int errors = 0;

   // Expected responses: {port, data}
   logic [DATA_W:0] exp_q[$];

   sand_mem_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .MAX_OUTST  (4),
      .STARVE_LIM (8)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .p0_address        (p0_address),
      .p0_read           (p0_read),
      .p0_waitrequest    (p0_waitrequest),
      .p0_readdatavalid  (p0_readdatavalid),
      .p0_readdata       (p0_readdata),
      .p1_address        (p1_address),
      .p1_read           (p1_read),
      .p1_write          (p1_write),
      .p1_writedata      (p1_writedata),
      .p1_waitrequest    (p1_waitrequest),
      .p1_readdatavalid  (p1_readdatavalid),
      .p1_readdata       (p1_readdata),
      .mem_address       (mem_address),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .mem_writedata     (mem_writedata),
      .mem_waitrequest   (mem_waitrequest),
      .mem_readdatavalid (mem_readdatavalid),
      .mem_readdata      (mem_readdata),
      .rsp_error         (rsp_error)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Falling-edge sample; any response is popped against the scoreboard.
   task automatic sample();
      logic [DATA_W:0]   e;
      logic [DATA_W-1:0] got_d;
      @(negedge clock);
      if (p0_readdatavalid || p1_readdatavalid) begin
         checks++;
         got_d = p1_readdatavalid ? p1_readdata : p0_readdata;
         if (p0_readdatavalid && p1_readdatavalid) begin
            errors++;
            $display("FAIL rsp_cross_valid: p0v=1 p1v=1, required exactly one");
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: p0v=%0b p1v=%0b data=%h, required no response",
                     p0_readdatavalid, p1_readdatavalid, got_d);
         end else begin
            e = exp_q.pop_front();
            if (p1_readdatavalid !== e[DATA_W] || got_d !== e[DATA_W-1:0]) begin
               errors++;
               $display("FAIL rsp_route: got port %0d data %h, required port %0d data %h",
                        p1_readdatavalid, got_d, e[DATA_W], e[DATA_W-1:0]);
            end
         end
      end
   endtask

   task automatic idle_inputs();
      p0_address        = '0;
      p0_read           = 1'b0;
      p1_address        = '0;
      p1_read           = 1'b0;
      p1_write          = 1'b0;
      p1_writedata      = '0;
      mem_waitrequest   = 1'b0;
      mem_readdatavalid = 1'b0;
      mem_readdata      = '0;
      exp_q.delete();
   endtask

   task automatic reset_dut();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      p0_read    = 1'b1;
      p0_address = 24'h123456;
      reset      = 1'b0;
      step();
      sample();
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_mem_cmd: read=%b write=%b, required 0 0", mem_read, mem_write);
      end
      checks++;
      if (p0_waitrequest !== 1'b1 || p1_waitrequest !== 1'b1) begin
         errors++;
         $display("FAIL reset_wait: p0=%b p1=%b, required 1 1", p0_waitrequest, p1_waitrequest);
      end
      checks++;
      if (mem_address !== 24'h0 || mem_writedata !== 16'h0 || rsp_error !== 1'b0 ||
          p0_readdatavalid !== 1'b0 || p1_readdatavalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: addr=%h wd=%h err=%b v0=%b v1=%b, required all 0",
                  mem_address, mem_writedata, rsp_error, p0_readdatavalid, p1_readdatavalid);
      end
      step();
      reset = 1'b1;
      sample();
      checks++;
      if (mem_read !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: mem_read=%b, required 0", mem_read);
      end
      step();
      sample();
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 24'h123456 || p0_waitrequest !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_grant: read=%b addr=%h wait0=%b, required 1 123456 0",
                  mem_read, mem_address, p0_waitrequest);
      end
      step();
      p0_read = 1'b0;
   endtask

   task automatic test_contention();
      int   idx;
      logic acc_rd;
      logic acc_wr;
      logic want_p1;
      idle_inputs();
      p0_address   = 24'h000100;
      p0_read      = 1'b1;
      p1_address   = 24'h800040;
      p1_writedata = 16'h2222;
      p1_write     = 1'b1;
      reset_dut();
      idx = 0;
      for (int c = 0; c < 60 && idx < 27; c++) begin
         sample();
         acc_rd = mem_read & ~mem_waitrequest;
         acc_wr = mem_write & ~mem_waitrequest;
         if (acc_rd || acc_wr) begin
            want_p1 = ((idx % 9) == 8);
            checks++;
            if (acc_wr !== want_p1) begin
               errors++;
               $display("FAIL contention_order[%0d]: got port %0d, required port %0d",
                        idx, acc_wr, want_p1);
            end
            checks++;
            if (acc_wr) begin
               if (mem_address !== 24'h800040 || mem_writedata !== 16'h2222) begin
                  errors++;
                  $display("FAIL contention_write[%0d]: addr=%h wd=%h, required 800040 2222",
                           idx, mem_address, mem_writedata);
               end
            end else if (mem_address !== 24'h000100) begin
               errors++;
               $display("FAIL contention_read[%0d]: addr=%h, required 000100", idx, mem_address);
            end
            idx++;
         end
         step();
         mem_readdatavalid = acc_rd;
         if (acc_rd) begin
            mem_readdata = 16'h1000 + 16'(c);
            exp_q.push_back({1'b0, mem_readdata});
         end
      end
      checks++;
      if (idx != 27) begin
         errors++;
         $display("FAIL contention_timeout: %0d acceptances, required 27", idx);
      end
      p0_read  = 1'b0;
      p1_write = 1'b0;
      sample();
      step();
      mem_readdatavalid = 1'b0;
      sample();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL contention_rsp_missing: %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_stall_lock();
      idle_inputs();
      mem_waitrequest = 1'b1;
      p1_write        = 1'b1;
      p1_address      = 24'h800077;
      p1_writedata    = 16'h3333;
      reset_dut();
      sample();
      step();
      p0_read    = 1'b1;
      p0_address = 24'h000055;
      for (int c = 0; c < 5; c++) begin
         sample();
         checks++;
         if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 24'h800077 ||
             mem_writedata !== 16'h3333 || p0_waitrequest !== 1'b1 || p1_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL stall_lock[%0d]: wr=%b rd=%b addr=%h wd=%h w0=%b w1=%b, required 1 0 800077 3333 1 1",
                     c, mem_write, mem_read, mem_address, mem_writedata, p0_waitrequest, p1_waitrequest);
         end
         step();
      end
      mem_waitrequest = 1'b0;
      sample();
      checks++;
      if (mem_write !== 1'b1 || p1_waitrequest !== 1'b0 || p0_waitrequest !== 1'b1) begin
         errors++;
         $display("FAIL stall_accept: wr=%b w1=%b w0=%b, required 1 0 1",
                  mem_write, p1_waitrequest, p0_waitrequest);
      end
      step();
      p1_write = 1'b0;
      sample();
      checks++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 24'h000055 ||
          p0_waitrequest !== 1'b0) begin
         errors++;
         $display("FAIL stall_then_p0: rd=%b wr=%b addr=%h w0=%b, required 1 0 000055 0",
                  mem_read, mem_write, mem_address, p0_waitrequest);
      end
      step();
      p0_read = 1'b0;
   endtask

   task automatic test_routing();
      logic found;
      idle_inputs();
      p0_read    = 1'b1;
      p0_address = 24'h000010;
      reset_dut();
      sample();
      step();
      sample();
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 24'h000010) begin
         errors++;
         $display("FAIL route_p0_issue: rd=%b addr=%h, required 1 000010", mem_read, mem_address);
      end
      step();
      p0_read    = 1'b0;
      p1_read    = 1'b1;
      p1_address = 24'h000020;
      found      = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
         sample();
         if (mem_read && !mem_waitrequest && mem_address == 24'h000020) found = 1'b1;
         step();
      end
      p1_read = 1'b0;
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL route_p1_issue: p1 read not accepted, required within 6 cycles");
      end
      mem_readdatavalid = 1'b1;
      mem_readdata      = 16'hAAAA;
      exp_q.push_back({1'b0, 16'hAAAA});
      sample();
      checks++;
      if (p0_readdatavalid !== 1'b1 || p1_readdatavalid !== 1'b0) begin
         errors++;
         $display("FAIL route_first: v0=%b v1=%b, required 1 0", p0_readdatavalid, p1_readdatavalid);
      end
      step();
      mem_readdata = 16'hBBBB;
      exp_q.push_back({1'b1, 16'hBBBB});
      sample();
      checks++;
      if (p0_readdatavalid !== 1'b0 || p1_readdatavalid !== 1'b1) begin
         errors++;
         $display("FAIL route_second: v0=%b v1=%b, required 0 1", p0_readdatavalid, p1_readdatavalid);
      end
      step();
      mem_readdatavalid = 1'b0;
      sample();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL route_rsp_missing: %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_fifo_full();
      int n;
      idle_inputs();
      p0_read    = 1'b1;
      p0_address = 24'h000200;
      reset_dut();
      n = 0;
      for (int c = 0; c < 12 && n < 4; c++) begin
         sample();
         if (mem_read && !mem_waitrequest) n++;
         step();
      end
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL full_fill: %0d reads accepted, required 4", n);
      end
      for (int c = 0; c < 2; c++) begin
         sample();
         checks++;
         if (mem_read !== 1'b0 || p0_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL full_hold[%0d]: rd=%b w0=%b, required 0 1", c, mem_read, p0_waitrequest);
         end
         step();
      end
      p1_write     = 1'b1;
      p1_address   = 24'h800099;
      p1_writedata = 16'h5555;
      sample();
      step();
      sample();
      checks++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 24'h800099 ||
          p1_waitrequest !== 1'b0) begin
         errors++;
         $display("FAIL full_write_granted: wr=%b rd=%b addr=%h w1=%b, required 1 0 800099 0",
                  mem_write, mem_read, mem_address, p1_waitrequest);
      end
      step();
      p1_write = 1'b0;
      sample();
      step();
      mem_readdatavalid = 1'b1;
      mem_readdata      = 16'hC0DE;
      exp_q.push_back({1'b0, 16'hC0DE});
      sample();
      checks++;
      if (mem_read !== 1'b0) begin
         errors++;
         $display("FAIL full_pop_cycle: rd=%b, required 0", mem_read);
      end
      step();
      mem_readdatavalid = 1'b0;
      sample();
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 24'h000200 || p0_waitrequest !== 1'b0) begin
         errors++;
         $display("FAIL full_reissue: rd=%b addr=%h w0=%b, required 1 000200 0",
                  mem_read, mem_address, p0_waitrequest);
      end
      step();
      p0_read = 1'b0;
      sample();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL full_rsp_missing: %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_error_reset();
      int n;
      idle_inputs();
      reset_dut();
      mem_readdatavalid = 1'b1;
      mem_readdata      = 16'hDEAD;
      sample();
      checks++;
      if (p0_readdatavalid !== 1'b0 || p1_readdatavalid !== 1'b0 || rsp_error !== 1'b0) begin
         errors++;
         $display("FAIL err_drop: v0=%b v1=%b err=%b, required 0 0 0",
                  p0_readdatavalid, p1_readdatavalid, rsp_error);
      end
      step();
      mem_readdatavalid = 1'b0;
      sample();
      checks++;
      if (rsp_error !== 1'b1) begin
         errors++;
         $display("FAIL err_set: rsp_error=%b, required 1", rsp_error);
      end
      step();
      step();
      sample();
      checks++;
      if (rsp_error !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: rsp_error=%b, required 1", rsp_error);
      end
      step();
      p0_read    = 1'b1;
      p0_address = 24'h000300;
      n = 0;
      for (int c = 0; c < 10 && n < 3; c++) begin
         sample();
         if (mem_read && !mem_waitrequest) n++;
         step();
      end
      p0_read = 1'b0;
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL err_inflight: %0d reads accepted, required 3", n);
      end
      reset = 1'b0;
      sample();
      checks++;
      if (rsp_error !== 1'b0 || mem_read !== 1'b0 || p0_waitrequest !== 1'b1) begin
         errors++;
         $display("FAIL err_reset_clear: err=%b rd=%b w0=%b, required 0 0 1",
                  rsp_error, mem_read, p0_waitrequest);
      end
      step();
      reset             = 1'b1;
      mem_readdatavalid = 1'b1;
      mem_readdata      = 16'hBEEF;
      sample();
      checks++;
      if (p0_readdatavalid !== 1'b0 || p1_readdatavalid !== 1'b0) begin
         errors++;
         $display("FAIL err_fifo_flushed: v0=%b v1=%b, required 0 0",
                  p0_readdatavalid, p1_readdatavalid);
      end
      step();
      mem_readdatavalid = 1'b0;
      sample();
      checks++;
      if (rsp_error !== 1'b1) begin
         errors++;
         $display("FAIL err_after_flush: rsp_error=%b, required 1", rsp_error);
      end
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      test_reset();
      test_contention();
      test_stall_lock();
      test_routing();
      test_fifo_full();
      test_error_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
